// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: opcodes, fetch FSM states, default bubble word.
`default_nettype none

package mips_pipe_pkg;

  localparam logic [5:0]  OP_HLT      = 6'b010001;
  localparam logic [5:0]  OP_LD       = 6'b010100;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fsr_state_t;

  // Jump family: op[5]=0 with op[4:2]=111, low two bits select the variant.
  function automatic logic is_jmp(input logic [5:0] op);
    return (op[5] == 1'b0) && (op[4:2] == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_pc_counter.sv
// Program counter register: load has priority over increment, otherwise hold; wraps mod 2^PC_W.
`default_nettype none

module fetch_pc_counter #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_addr,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stall_responder.sv
// Fetch-side stall handshake: PC hold, NOP bubbles, jump redirect, halt freeze.
// Optional saturating stall counter enabled by `FSR_STALL_CNT_EN.
`default_nettype none

module fetch_stall_responder
  import mips_pipe_pkg::*;
#(
  parameter int unsigned      PC_W  = 8,
  parameter int unsigned      INS_W = 32,
  parameter logic [INS_W-1:0] NOP   = {INS_W{1'b0}},
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             stall_pm,
  input  logic             jmp_en,
  input  logic [PC_W-1:0]  jmp_addr,
  input  logic [INS_W-1:0] pm_data,
  output logic [PC_W-1:0]  pc_out,
  output logic             pm_rd_en,
  output logic [INS_W-1:0] ins_out,
  output logic             ins_valid,
  output logic             halted
`ifdef FSR_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  fsr_state_t       state, state_nxt;
  logic [INS_W-1:0] ins_nxt;
  logic             valid_nxt;
  logic             pc_load;
  logic             pc_inc;
  logic             hlt_in_decode;

  assign hlt_in_decode = ins_valid && (ins_out[INS_W-1 -: 6] == OP_HLT);

  fetch_pc_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (jmp_addr),
    .pc        (pc_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      ins_out   <= NOP;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ins_out   <= ins_nxt;
      ins_valid <= valid_nxt;
    end
  end

  // Priority: jump > halt detect > memory-gated bubble > replay hold > normal fetch.
  always_comb begin
    state_nxt = state;
    ins_nxt   = ins_out;
    valid_nxt = ins_valid;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    if (state == ST_RUN) begin
      if (jmp_en) begin
        pc_load   = 1'b1;
        ins_nxt   = NOP;
        valid_nxt = 1'b0;
      end else if (stall && hlt_in_decode) begin
        state_nxt = ST_HALT;
      end else if (stall_pm) begin
        ins_nxt   = NOP;
        valid_nxt = 1'b0;
      end else if (!stall) begin
        ins_nxt   = pm_data;
        valid_nxt = 1'b1;
        pc_inc    = 1'b1;
      end
    end
  end

  assign pm_rd_en = (state == ST_RUN) && !stall && !stall_pm;
  assign halted   = (state == ST_HALT);

`ifdef FSR_STALL_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == ST_RUN) && (stall || stall_pm) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stall_cycles = cnt;
`endif

endmodule

`default_nettype wire
